// File: rtl/ct_ifu_sram_ctrl_pkg.sv
// Shared types and constants for the IFU single-port SRAM controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ct_ifu_sram_ctrl_pkg;

  localparam int SRAM_AW = 8;
  localparam int SRAM_DW = 23;

  // Number of entries addressed by an aw-bit address.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  localparam int SRAM_DEPTH = depth_of(SRAM_AW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } ctrl_state_e;

  // Macro control pins are active-low.
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic GWEN_WR = 1'b0;
  localparam logic GWEN_RD = 1'b1;

  localparam logic [SRAM_DW-1:0] WEN_ALL_ON = '0;

endpackage

// File: rtl/ct_ifu_spsram_256x23_ctrl.sv
// Initiator-side controller for one 256x23 IFU single-port SRAM: init sweep, then wr/rd arbitration.
// Latency: SRAM pins driven combinationally in the accept cycle; read data returned exactly 1 cycle later.
// Backpressure: both rdy low outside READY and on init_req; write beats read; responses cannot be stalled.
//
// Ports:
//   forever_cpuclk / cpurst_b      : clock, async active-low reset
//   init_req / init_done           : re-run invalidate sweep / array ready
//   wr_req_*                       : write request (addr, data, active-high bit mask)
//   rd_req_*                       : read request (addr)
//   rd_rsp_vld / rd_rsp_data       : read response, data held between responses
//   sram_a/cen/gwen/wen/d, sram_q  : macro interface, enables active-low
module ct_ifu_spsram_256x23_ctrl
  import ct_ifu_sram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = SRAM_AW,
  parameter int                    DATA_WIDTH = SRAM_DW,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  wr_req_vld,
  output logic                  wr_req_rdy,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  rd_req_vld,
  output logic                  rd_req_rdy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_vld,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int                    DEPTH    = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] WEN_ON   = DATA_WIDTH'(WEN_ALL_ON);
  localparam logic [DATA_WIDTH-1:0] WEN_OFF  = ~WEN_ON;

  ctrl_state_e           r_state;
  ctrl_state_e           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_hold;
  logic                  w_rd_fire;

  // State and sweep counter.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, arbitration and macro pin drive.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    init_done   = 1'b0;
    wr_req_rdy  = 1'b0;
    rd_req_rdy  = 1'b0;
    w_rd_fire   = 1'b0;
    sram_cen    = CEN_OFF;
    sram_gwen   = GWEN_RD;
    sram_wen    = WEN_OFF;
    sram_a      = '0;
    sram_d      = '0;

    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end

      ST_INIT: begin
        sram_cen  = CEN_ON;
        sram_gwen = GWEN_WR;
        sram_wen  = WEN_ON;
        sram_a    = r_cnt;
        sram_d    = INIT_VALUE;
        // Counter wraps to 0 on the last entry, leaving it ready for the next sweep.
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_READY;
        end
      end

      ST_READY: begin
        init_done = 1'b1;
        if (init_req) begin
          // Nothing is accepted in the request cycle so the sweep starts on a quiet port.
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end else begin
          wr_req_rdy = 1'b1;
          rd_req_rdy = !wr_req_vld;
          if (wr_req_vld) begin
            sram_cen  = CEN_ON;
            sram_gwen = GWEN_WR;
            sram_wen  = ~wr_mask;
            sram_a    = wr_addr;
            sram_d    = wr_data;
          end else if (rd_req_vld) begin
            sram_cen  = CEN_ON;
            sram_gwen = GWEN_RD;
            sram_a    = rd_addr;
            w_rd_fire = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Response tracking: Q is only meaningful the cycle after a read, so it is
  // captured then and replayed from the hold register afterwards.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_hold <= '0;
    end else begin
      r_rsp_vld <= w_rd_fire;
      if (r_rsp_vld) begin
        r_rsp_hold <= sram_q;
      end
    end
  end

  assign rd_rsp_vld  = r_rsp_vld;
  assign rd_rsp_data = r_rsp_vld ? sram_q : r_rsp_hold;

endmodule

// File: tb/tb_ct_ifu_spsram_256x23_ctrl.sv
// Bench for ct_ifu_spsram_256x23_ctrl with a behavioural 256x23 macro model.
// Latency: checks 1-cycle read response against a cycle-stamped scoreboard.
// Backpressure: checks rdy gating in INIT, on init_req and write-over-read priority.
module tb_ct_ifu_spsram_256x23_ctrl;
  import ct_ifu_sram_ctrl_pkg::*;

  localparam logic [22:0] ONES = 23'h7FFFFF;

  logic        clk;
  logic        cpurst_b;
  logic        init_req;
  logic        init_done;
  logic        wr_req_vld;
  logic        wr_req_rdy;
  logic [7:0]  wr_addr;
  logic [22:0] wr_data;
  logic [22:0] wr_mask;
  logic        rd_req_vld;
  logic        rd_req_rdy;
  logic [7:0]  rd_addr;
  logic        rd_rsp_vld;
  logic [22:0] rd_rsp_data;
  logic [7:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [22:0] sram_wen;
  logic [22:0] sram_d;
  logic [22:0] sram_q;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ct_ifu_spsram_256x23_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst_b      (cpurst_b),
    .init_req      (init_req),
    .init_done     (init_done),
    .wr_req_vld    (wr_req_vld),
    .wr_req_rdy    (wr_req_rdy),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_mask       (wr_mask),
    .rd_req_vld    (rd_req_vld),
    .rd_req_rdy    (rd_req_rdy),
    .rd_addr       (rd_addr),
    .rd_rsp_vld    (rd_rsp_vld),
    .rd_rsp_data   (rd_rsp_data),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: per-bit write, Q valid after a read, garbage otherwise.
  logic [22:0] mem [SRAM_DEPTH];
  always @(posedge clk) begin
    if (!sram_cen && !sram_gwen) begin
      mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      sram_q      <= 23'($urandom);
    end else if (!sram_cen) begin
      sram_q <= mem[sram_a];
    end else begin
      sram_q <= 23'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected read responses, stamped with the cycle they are due.
  typedef struct {
    int          due;
    logic [22:0] data;
  } exp_t;
  exp_t sb[$];
  logic [22:0] ref_mem [SRAM_DEPTH];

  task automatic push_rd(input logic [7:0] a);
    exp_t e;
    e.due  = cyc + 1;
    e.data = ref_mem[a];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_rsp_vld) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rd_rsp_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_data", 32'(rd_rsp_data), 32'(e.data));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("rsp_missing", 32'(rd_rsp_vld), 32'd1);
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cen"}, 32'(sram_cen), 32'd1);
    chk({tag, "_gwen"}, 32'(sram_gwen), 32'd1);
    chk({tag, "_wen"}, 32'(sram_wen), 32'(ONES));
    chk({tag, "_a"}, 32'(sram_a), 32'd0);
    chk({tag, "_d"}, 32'(sram_d), 32'd0);
    chk({tag, "_wr_rdy"}, 32'(wr_req_rdy), 32'd0);
    chk({tag, "_rd_rdy"}, 32'(rd_req_rdy), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(rd_rsp_vld), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rd_rsp_data), 32'd0);
  endtask

  // Checks n sweep cycles, requests held high and one init_req pulse that must be ignored.
  task automatic run_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_req_vld = 1'b1;
      rd_req_vld = 1'b1;
      init_req   = (i == 50);
      @(negedge clk);
      chk("sweep_cen", 32'(sram_cen), 32'd0);
      chk("sweep_gwen", 32'(sram_gwen), 32'd0);
      chk("sweep_wen", 32'(sram_wen), 32'd0);
      chk("sweep_a", 32'(sram_a), 32'(i));
      chk("sweep_d", 32'(sram_d), 32'd0);
      chk("sweep_wr_rdy", 32'(wr_req_rdy), 32'd0);
      chk("sweep_rd_rdy", 32'(rd_req_rdy), 32'd0);
      chk("sweep_init_done", 32'(init_done), 32'd0);
    end
    init_req = 1'b0;
  endtask

  task automatic chk_ready_cycle();
    @(negedge clk);
    chk("ready_init_done", 32'(init_done), 32'd1);
    chk("ready_wr_rdy", 32'(wr_req_rdy), 32'd1);
  endtask

  typedef struct {
    logic        wv;
    logic [7:0]  wa;
    logic [22:0] wd;
    logic [22:0] wm;
    logic        rv;
    logic [7:0]  ra;
    logic        ewr;
    logic        erd;
    logic        ecen;
    logic        egwen;
    logic [7:0]  ea;
    logic [22:0] ewen;
    logic [22:0] ed;
    logic        crsp;
    logic [22:0] ersp;
  } vec_t;
  vec_t vt [18];

  initial begin
    cpurst_b   = 1'b0;
    init_req   = 1'b0;
    wr_req_vld = 1'b1;
    wr_addr    = 8'h11;
    wr_data    = 23'h1;
    wr_mask    = ONES;
    rd_req_vld = 1'b1;
    rd_addr    = 8'h22;

    //        wv  wa     wd          wm          rv  ra     ewr erd cen gwn ea     ewen        ed          crsp ersp
    vt[0]  = '{1, 8'h5A, ONES,       ONES,       0, 8'h00, 1, 0, 0, 0, 8'h5A, 23'h000000, ONES,       0, 23'h0};
    vt[1]  = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h5A, 1, 1, 0, 1, 8'h5A, ONES,       23'h000000, 0, 23'h0};
    vt[2]  = '{0, 8'h00, 23'h0,      23'h0,      0, 8'h00, 1, 1, 1, 1, 8'h00, ONES,       23'h000000, 1, ONES};
    vt[3]  = '{0, 8'h00, 23'h0,      23'h0,      0, 8'h00, 1, 1, 1, 1, 8'h00, ONES,       23'h000000, 1, ONES};
    vt[4]  = '{1, 8'h10, ONES,       23'h0000FF, 0, 8'h00, 1, 0, 0, 0, 8'h10, 23'h7FFF00, ONES,       0, 23'h0};
    vt[5]  = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h10, 1, 1, 0, 1, 8'h10, ONES,       23'h000000, 0, 23'h0};
    vt[6]  = '{1, 8'h01, 23'h123456, ONES,       1, 8'h02, 1, 0, 0, 0, 8'h01, 23'h000000, 23'h123456, 1, 23'h0000FF};
    vt[7]  = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h02, 1, 1, 0, 1, 8'h02, ONES,       23'h000000, 0, 23'h0};
    vt[8]  = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h01, 1, 1, 0, 1, 8'h01, ONES,       23'h000000, 0, 23'h0};
    vt[9]  = '{0, 8'h00, 23'h0,      23'h0,      0, 8'h00, 1, 1, 1, 1, 8'h00, ONES,       23'h000000, 0, 23'h0};
    vt[10] = '{1, 8'h5A, 23'h0,      23'h0,      0, 8'h00, 1, 0, 0, 0, 8'h5A, ONES,       23'h000000, 0, 23'h0};
    vt[11] = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h5A, 1, 1, 0, 1, 8'h5A, ONES,       23'h000000, 0, 23'h0};
    vt[12] = '{1, 8'h33, 23'h0ABCDE, ONES,       0, 8'h00, 1, 0, 0, 0, 8'h33, 23'h000000, 23'h0ABCDE, 0, 23'h0};
    vt[13] = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h33, 1, 1, 0, 1, 8'h33, ONES,       23'h000000, 0, 23'h0};
    vt[14] = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h10, 1, 1, 0, 1, 8'h10, ONES,       23'h000000, 1, 23'h0ABCDE};
    vt[15] = '{0, 8'h00, 23'h0,      23'h0,      1, 8'h01, 1, 1, 0, 1, 8'h01, ONES,       23'h000000, 1, 23'h0000FF};
    vt[16] = '{0, 8'h00, 23'h0,      23'h0,      0, 8'h00, 1, 1, 1, 1, 8'h00, ONES,       23'h000000, 1, 23'h123456};
    vt[17] = '{0, 8'h00, 23'h0,      23'h0,      0, 8'h00, 1, 1, 1, 1, 8'h00, ONES,       23'h000000, 1, 23'h123456};

    // Reset and first sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    @(negedge clk);
    chk_reset_outs("idle");
    run_sweep(SRAM_DEPTH);
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b0;
    chk_ready_cycle();
    chk("ready_cen", 32'(sram_cen), 32'd1);
    chk("ready_rd_rdy", 32'(rd_req_rdy), 32'd1);
    for (int i = 0; i < SRAM_DEPTH; i++) ref_mem[i] = 23'h0;

    // Single-cycle vectors.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      wr_req_vld = vt[i].wv;
      wr_addr    = vt[i].wa;
      wr_data    = vt[i].wd;
      wr_mask    = vt[i].wm;
      rd_req_vld = vt[i].rv;
      rd_addr    = vt[i].ra;
      if (vt[i].wv && vt[i].ewr)
        ref_mem[vt[i].wa] = (ref_mem[vt[i].wa] & ~vt[i].wm) | (vt[i].wd & vt[i].wm);
      if (vt[i].rv && vt[i].erd) push_rd(vt[i].ra);
      @(negedge clk);
      chk($sformatf("v%0d_wr_rdy", i), 32'(wr_req_rdy), 32'(vt[i].ewr));
      chk($sformatf("v%0d_rd_rdy", i), 32'(rd_req_rdy), 32'(vt[i].erd));
      chk($sformatf("v%0d_cen", i), 32'(sram_cen), 32'(vt[i].ecen));
      chk($sformatf("v%0d_gwen", i), 32'(sram_gwen), 32'(vt[i].egwen));
      chk($sformatf("v%0d_a", i), 32'(sram_a), 32'(vt[i].ea));
      chk($sformatf("v%0d_wen", i), 32'(sram_wen), 32'(vt[i].ewen));
      chk($sformatf("v%0d_d", i), 32'(sram_d), 32'(vt[i].ed));
      if (vt[i].crsp) chk($sformatf("v%0d_rsp_data", i), 32'(rd_rsp_data), 32'(vt[i].ersp));
    end

    // Read accepted the cycle before init_req still returns its response.
    @(posedge clk); #1;
    rd_req_vld = 1'b1;
    rd_addr    = 8'h33;
    push_rd(8'h33);
    @(negedge clk);
    chk("pre_init_rd_rdy", 32'(rd_req_rdy), 32'd1);
    @(posedge clk); #1;
    init_req = 1'b1;
    rd_addr  = 8'h5A;
    @(negedge clk);
    chk("init_req_wr_rdy", 32'(wr_req_rdy), 32'd0);
    chk("init_req_rd_rdy", 32'(rd_req_rdy), 32'd0);
    chk("init_req_cen", 32'(sram_cen), 32'd1);
    chk("init_req_init_done", 32'(init_done), 32'd1);
    run_sweep(SRAM_DEPTH);
    for (int i = 0; i < SRAM_DEPTH; i++) ref_mem[i] = 23'h0;
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b1;
    rd_addr    = 8'h5A;
    push_rd(8'h5A);
    chk_ready_cycle();
    chk("reinit_rd_rdy", 32'(rd_req_rdy), 32'd1);
    @(posedge clk); #1;
    rd_addr = 8'h10;
    push_rd(8'h10);
    @(posedge clk); #1;
    rd_addr = 8'h33;                 // accepted, response dropped by reset below
    @(posedge clk); #1;
    rd_req_vld = 1'b0;
    cpurst_b   = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_rd");

    // Reset in the middle of a sweep restarts it from address 0.
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    @(negedge clk);
    chk_reset_outs("idle2");
    run_sweep(101);
    #1 cpurst_b = 1'b0;
    #1 chk_reset_outs("rst_init");
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    @(negedge clk);
    chk_reset_outs("idle3");
    run_sweep(SRAM_DEPTH);
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b1;
    rd_addr    = 8'h01;
    push_rd(8'h01);
    chk_ready_cycle();
    @(posedge clk); #1;
    rd_req_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
